// File: rtl/clk_ctrl.sv
`default_nettype none
// ============================================================================
// clk_ctrl : CPU clock-enable controller (HALT/RUN/DIV/STEP, sticky halt)
// Rev 1.0
// ============================================================================
module clk_ctrl #(
  parameter int DIV_W     = 21,
  parameter int DB_CYCLES = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       mode,
  input  logic [DIV_W-1:0] div_val,
  input  logic             step_btn,
  input  logic             halt_req,
  input  logic             resume,
  output logic             cpu_ce,
  output logic             halted,
  output logic [1:0]       state,
  output logic [31:0]      cycle_cnt
);

  localparam int c_DB_W = $clog2(DB_CYCLES + 1);

  typedef enum logic [1:0] {
    ST_HALT = 2'b00,
    ST_RUN  = 2'b01,
    ST_DIV  = 2'b10,
    ST_STEP = 2'b11
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_halted;
  logic                w_halted_nxt;
  logic                r_cpu_ce;
  logic                w_ce_nxt;
  logic [31:0]         r_cycle_cnt;
  logic [DIV_W-1:0]    r_div_cnt;
  logic [DIV_W-1:0]    w_div_cnt_nxt;
  logic                r_sync1;
  logic                r_sync2;
  logic                r_db_stable;
  logic                w_db_stable_nxt;
  logic [c_DB_W-1:0]   r_db_cnt;
  logic [c_DB_W-1:0]   w_db_cnt_nxt;
  logic                w_db_rise;

  // Debounce: count consecutive samples that disagree with the stable level.
  always_comb begin
    w_db_stable_nxt = r_db_stable;
    w_db_cnt_nxt    = '0;
    if (r_sync2 != r_db_stable) begin
      if (r_db_cnt == c_DB_W'(DB_CYCLES - 1)) begin
        w_db_stable_nxt = r_sync2;
      end else begin
        w_db_cnt_nxt = r_db_cnt + c_DB_W'(1);
      end
    end
    w_db_rise = w_db_stable_nxt & ~r_db_stable;
  end

  always_comb begin
    w_halted_nxt  = r_halted;
    w_state_nxt   = state_t'(mode);
    w_ce_nxt      = 1'b0;
    w_div_cnt_nxt = '0;
    if (halt_req) begin
      w_halted_nxt = 1'b1;
    end else if (resume) begin
      w_halted_nxt = 1'b0;
    end
    if (w_halted_nxt) begin
      w_state_nxt = ST_HALT;
    end
    case (w_state_nxt)
      ST_RUN:  w_ce_nxt = 1'b1;
      // Entry edge only clears the count, so the first pulse lands div_val+1 cycles in.
      ST_DIV: begin
        if (r_state == ST_DIV) begin
          if (r_div_cnt >= div_val) begin
            w_ce_nxt = 1'b1;
          end else begin
            w_div_cnt_nxt = r_div_cnt + DIV_W'(1);
          end
        end
      end
      ST_STEP: w_ce_nxt = w_db_rise;
      default: w_ce_nxt = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_HALT;
      r_halted    <= 1'b0;
      r_cpu_ce    <= 1'b0;
      r_cycle_cnt <= '0;
      r_div_cnt   <= '0;
      r_sync1     <= 1'b0;
      r_sync2     <= 1'b0;
      r_db_stable <= 1'b0;
      r_db_cnt    <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_halted    <= w_halted_nxt;
      r_cpu_ce    <= w_ce_nxt;
      r_cycle_cnt <= r_cycle_cnt + {31'd0, r_cpu_ce};
      r_div_cnt   <= w_div_cnt_nxt;
      r_sync1     <= step_btn;
      r_sync2     <= r_sync1;
      r_db_stable <= w_db_stable_nxt;
      r_db_cnt    <= w_db_cnt_nxt;
    end
  end

  assign cpu_ce    = r_cpu_ce;
  assign halted    = r_halted;
  assign state     = r_state;
  assign cycle_cnt = r_cycle_cnt;

endmodule
`default_nettype wire

// File: tb/tb_clk_ctrl.sv
`default_nettype none
// ============================================================================
// tb_clk_ctrl : scoreboard bench for clk_ctrl with directed vectors
// Rev 1.0
// ============================================================================
module tb_clk_ctrl;

  logic        clk;
  logic        rst;
  logic [1:0]  mode;
  logic [20:0] div_val;
  logic        step_btn;
  logic        halt_req;
  logic        resume;
  logic        cpu_ce;
  logic        halted;
  logic [1:0]  state;
  logic [31:0] cycle_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    string       name;
    logic [3:0]  mask;
    logic        ce;
    logic        h;
    logic [1:0]  st;
    logic [31:0] cnt;
  } exp_t;

  exp_t q[$];

  clk_ctrl #(.DIV_W(21), .DB_CYCLES(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .mode     (mode),
    .div_val  (div_val),
    .step_btn (step_btn),
    .halt_req (halt_req),
    .resume   (resume),
    .cpu_ce   (cpu_ce),
    .halted   (halted),
    .state    (state),
    .cycle_cnt(cycle_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  // Monitor: outputs settle after each posedge; compare against the head entry.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        if (e.mask[0]) begin
          n_tests++;
          if (cpu_ce !== e.ce) begin
            n_fail++;
            $display("FAIL %s cpu_ce got %0b want %0b @%0t", e.name, cpu_ce, e.ce, $time);
          end
        end
        if (e.mask[1]) begin
          n_tests++;
          if (halted !== e.h) begin
            n_fail++;
            $display("FAIL %s halted got %0b want %0b @%0t", e.name, halted, e.h, $time);
          end
        end
        if (e.mask[2]) begin
          n_tests++;
          if (state !== e.st) begin
            n_fail++;
            $display("FAIL %s state got %0d want %0d @%0t", e.name, state, e.st, $time);
          end
        end
        if (e.mask[3]) begin
          n_tests++;
          if (cycle_cnt !== e.cnt) begin
            n_fail++;
            $display("FAIL %s cycle_cnt got %h want %h @%0t", e.name, cycle_cnt, e.cnt, $time);
          end
        end
      end
    end
  end

  // Push the expectation for the outputs after the coming posedge, then advance.
  task automatic chk(input string name, input logic [3:0] mask, input logic ce,
                     input logic h, input logic [1:0] st, input logic [31:0] cnt);
    exp_t e;
    e.name = name; e.mask = mask; e.ce = ce; e.h = h; e.st = st; e.cnt = cnt;
    q.push_back(e);
    @(negedge clk);
  endtask

  task automatic reset_dut();
    rst = 1'b1; halt_req = 1'b0; resume = 1'b0; step_btn = 1'b0;
    chk("reset", 4'hF, 1'b0, 1'b0, 2'b00, 32'd0);
    chk("reset", 4'hF, 1'b0, 1'b0, 2'b00, 32'd0);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; mode = 2'b01; div_val = '0; step_btn = 1'b0; halt_req = 1'b0; resume = 1'b0;
    @(negedge clk);

    // Reset with RUN requested, then free-running enables.
    for (int i = 0; i < 3; i++) chk("reset_run", 4'hF, 1'b0, 1'b0, 2'b00, 32'd0);
    rst = 1'b0;
    for (int k = 1; k <= 11; k++) chk("run", 4'b1101, 1'b1, 1'b0, 2'b01, 32'(k - 1));

    // Sticky halt, resume, and halt_req winning over resume.
    halt_req = 1'b1;               chk("halt_set",    4'b0111, 1'b0, 1'b1, 2'b00, 32'd0);
    halt_req = 1'b0;               chk("halt_sticky", 4'b0111, 1'b0, 1'b1, 2'b00, 32'd0);
    resume = 1'b1;                 chk("resume",      4'b0111, 1'b1, 1'b0, 2'b01, 32'd0);
    resume = 1'b0;                 chk("run_again",   4'b0111, 1'b1, 1'b0, 2'b01, 32'd0);
    halt_req = 1'b1; resume = 1'b1; chk("halt_wins",  4'b0111, 1'b0, 1'b1, 2'b00, 32'd0);
    halt_req = 1'b0; resume = 1'b0; chk("still_halt", 4'hF,    1'b0, 1'b1, 2'b00, 32'd13);

    // DIV by 4, then div_val=0, then shrinking div_val below the count.
    reset_dut();
    mode = 2'b10; div_val = 21'd3;
    chk("div_entry", 4'b0101, 1'b0, 1'b0, 2'b10, 32'd0);
    for (int k = 1; k <= 16; k++) chk("div3", 4'b0001, (k % 4) == 0, 1'b0, 2'b00, 32'd0);
    div_val = 21'd0;
    for (int k = 0; k < 6; k++) chk("div0", 4'b0001, 1'b1, 1'b0, 2'b00, 32'd0);
    div_val = 21'd10;
    for (int k = 0; k < 5; k++) chk("div10", 4'b0001, 1'b0, 1'b0, 2'b00, 32'd0);
    div_val = 21'd2;
    chk("div_shrink", 4'b0001, 1'b1, 1'b0, 2'b00, 32'd0);

    // Partial divide discarded on mode change.
    reset_dut();
    mode = 2'b10; div_val = 21'd100;
    chk("div100_entry", 4'b0101, 1'b0, 1'b0, 2'b10, 32'd0);
    for (int k = 1; k <= 50; k++) chk("div100_a", 4'b0001, 1'b0, 1'b0, 2'b00, 32'd0);
    mode = 2'b01;
    for (int k = 0; k < 3; k++) chk("div_to_run", 4'b0101, 1'b1, 1'b0, 2'b01, 32'd0);
    mode = 2'b10;
    chk("div_reentry", 4'b0101, 1'b0, 1'b0, 2'b10, 32'd0);
    for (int k = 1; k <= 101; k++) chk("div100_b", 4'b0001, k == 101, 1'b0, 2'b00, 32'd0);

    // cycle_cnt wrap.
    reset_dut();
    mode = 2'b00;
    force dut.r_cycle_cnt = 32'hFFFF_FFFE;
    chk("preload", 4'b1001, 1'b0, 1'b0, 2'b00, 32'hFFFF_FFFE);
    release dut.r_cycle_cnt;
    chk("preload_hold", 4'b1001, 1'b0, 1'b0, 2'b00, 32'hFFFF_FFFE);
    mode = 2'b01;
    chk("wrap0", 4'b1001, 1'b1, 1'b0, 2'b00, 32'hFFFF_FFFE);
    chk("wrap1", 4'b1001, 1'b1, 1'b0, 2'b00, 32'hFFFF_FFFF);
    chk("wrap2", 4'b1001, 1'b1, 1'b0, 2'b00, 32'h0000_0000);

    // STEP: bouncing button yields one pulse after debounce.
    reset_dut();
    mode = 2'b11;
    for (int i = 0; i < 10; i++) begin
      step_btn = (i % 2) == 0;
      chk("bounce", 4'b1001, 1'b0, 1'b0, 2'b00, 32'd0);
    end
    step_btn = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (i == 5)       chk("step_wait", 4'b1000, 1'b0, 1'b0, 2'b00, 32'd0);
      else if (i == 39) chk("step_one",  4'b1001, 1'b0, 1'b0, 2'b00, 32'd1);
      else              chk("step_hold", 4'b0000, 1'b0, 1'b0, 2'b00, 32'd0);
    end
    step_btn = 1'b0;
    for (int i = 0; i < 30; i++) chk("step_rel", 4'b0001, 1'b0, 1'b0, 2'b00, 32'd0);
    chk("step_rel_cnt", 4'b1000, 1'b0, 1'b0, 2'b00, 32'd1);

    // A press debounced outside STEP must not fire later.
    mode = 2'b00; step_btn = 1'b1;
    for (int i = 0; i < 30; i++) chk("halt_press", 4'b0001, 1'b0, 1'b0, 2'b00, 32'd0);
    mode = 2'b11;
    for (int i = 0; i < 5; i++) chk("no_queue", 4'b1101, 1'b0, 1'b0, 2'b11, 32'd1);

    repeat (2) @(negedge clk);
    if (q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain queue got %0d want 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
